pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register that supersedes the fixed per-stage latch-and-zero registers.
- Carries a control bundle and a data bundle between any two pipeline stages, e.g. IF/ID, ID/EX, EX/MEM, MEM/WB.
- Adds a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never loses an in-flight instruction.
- Adds a synchronous flush and bubble (nop) generation with guaranteed-zero control on every bubble.

Parameters:
- CTRL_W, 11: width of the control bundle (EX/MEM/WB control bits); forced to zero on a bubble.
- DATA_W, 48: width of the data bundle (operands, register IDs, immediates).
- ZERO_DATA_ON_BUBBLE, 1: 1 = out_data forced to 0 when out_valid=0; 0 = out_data holds its last value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream presents an instruction; 0 = nop/bubble.
- in_ready  output  1  stage can accept this cycle.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- flush  input  1  kill every entry held in the stage (branch/halt squash).
- out_valid  output  1  stage presents a real instruction downstream.
- out_ready  input  1  downstream consumes this cycle.
- out_ctrl  output  CTRL_W  control to downstream; all-zero whenever out_valid=0.
- out_data  output  DATA_W  data to downstream.
- out_nop  output  1  equals ~out_valid, for existing nop-driven forwarding/hazard logic.
- occupancy  output  2  number of entries held: 0, 1 or 2.

Behaviour:
- Storage:
  - main entry {m_v, m_ctrl, m_data} drives the outputs.
  - skid entry {s_v, s_ctrl, s_data}.
- Occupancy:
  - EMPTY: m_v=0, s_v=0.
  - ONE: m_v=1, s_v=0.
  - FULL: m_v=1, s_v=1.
  - State m_v=0 with s_v=1 is illegal and never reached.
- Handshake:
  - in_ready = ~s_v. This is a combinational function of state only, not of out_ready.
  - Accept = in_valid & in_ready.
  - Consume = m_v & out_ready.
  - in_ctrl/in_data are ignored whenever Accept=0.
- Transitions (no flush, rst=0):
  - EMPTY: Accept -> main <= input; go to ONE.
  - ONE:
    - Accept & Consume -> main <= input; stay ONE.
    - Accept & !Consume -> skid <= input; go to FULL.
    - !Accept & Consume -> go to EMPTY.
    - Otherwise hold.
  - FULL: Accept is impossible (in_ready=0).
    - Consume -> main <= skid, s_v <= 0; go to ONE.
    - Otherwise hold.
- Latency and throughput:
  - An instruction accepted at edge N appears on out_* after edge N when the stage was EMPTY, or when it was ONE with a same-cycle Consume.
  - Sustained throughput is 1 instruction/cycle when out_ready stays high.
  - Strict in-order delivery: no reordering, no duplication, no drop except on flush.
- Flush:
  - On the next edge, m_v <= 0 and s_v <= 0. Flush overrides Accept and Consume in the same cycle.
  - An input presented during a flush cycle is dropped, even though in_ready may read 1.
  - in_ready is 1 the cycle after a flush.
- Bubbles:
  - out_ctrl = m_v ? m_ctrl : 0.
  - out_data = (m_v | !ZERO_DATA_ON_BUBBLE) ? m_data : 0.
- Reset (rst=1, synchronous):
  - Clears m_v, s_v and all stored ctrl/data to 0; takes priority over flush.
  - Outputs after the reset edge: out_valid=0, out_nop=1, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
  - A reset asserted mid-stream discards both entries.
- occupancy = m_v + s_v.

Test Plan:
- Reset, then in_valid=1, in_ctrl=0x5A5, in_data=0x123456 with out_ready=1 -> out_valid=1 and out_ctrl=0x5A5 one cycle later; occupancy=1.
- Stream 10 words (in_data=1..10) with out_ready low for cycles 3-5 -> in_ready drops only once occupancy=2; output sequence is exactly 1..10 with no gaps or repeats.
- FULL (skid=B, main=A), assert flush with in_valid=1 and out_ready=0 -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1; neither A, B nor the new input ever emerges.
- in_valid=0 for one cycle while upstream holds ctrl=0x7FF -> that slot yields out_nop=1, out_ctrl=0; with ZERO_DATA_ON_BUBBLE=0, out_data keeps the previous value.
- Stage at occupancy=2, assert rst together with flush and out_ready=1 -> after the edge all outputs are at reset values and in_ready=1; the first input after rst deasserts appears one cycle later.
- out_ready toggles pseudo-randomly for 1000 cycles while in_valid stays high -> a scoreboard confirms in-order delivery, that out_ctrl is 0 on every out_valid=0 cycle, and that occupancy never exceeds 2.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Flush and reset clear both entries; control is forced to zero on every bubble.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W              = 11,
  parameter int unsigned DATA_W              = 48,
  parameter bit          ZERO_DATA_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              out_nop,
  output logic [1:0]        occupancy
);

  logic              m_v_q, m_v_d;
  logic              s_v_q, s_v_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;

  logic accept;
  logic consume;

  assign in_ready = ~s_v_q;
  assign accept   = in_valid & ~s_v_q;
  assign consume  = m_v_q & out_ready;

  always_comb begin
    m_v_d    = m_v_q;
    s_v_d    = s_v_q;
    m_ctrl_d = m_ctrl_q;
    s_ctrl_d = s_ctrl_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush) begin
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else begin
      unique case (1'b1)
        !m_v_q: begin
          if (accept) begin
            m_v_d    = 1'b1;
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end
        end
        m_v_q && !s_v_q: begin
          if (accept && consume) begin
            m_ctrl_d = in_ctrl;
            m_data_d = in_data;
          end else if (accept) begin
            s_v_d    = 1'b1;
            s_ctrl_d = in_ctrl;
            s_data_d = in_data;
          end else if (consume) begin
            m_v_d = 1'b0;
          end
        end
        m_v_q && s_v_q: begin
          // skid drains into main; upstream is blocked while full
          if (consume) begin
            s_v_d    = 1'b0;
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_q    <= 1'b0;
      s_v_q    <= 1'b0;
      m_ctrl_q <= '0;
      s_ctrl_q <= '0;
      m_data_q <= '0;
      s_data_q <= '0;
    end else begin
      m_v_q    <= m_v_d;
      s_v_q    <= s_v_d;
      m_ctrl_q <= m_ctrl_d;
      s_ctrl_q <= s_ctrl_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
    end
  end

  assign out_valid = m_v_q;
  assign out_nop   = ~m_v_q;
  assign out_ctrl  = m_v_q ? m_ctrl_q : '0;
  assign out_data  = (m_v_q || !ZERO_DATA_ON_BUBBLE) ? m_data_q : '0;
  assign occupancy = {1'b0, m_v_q} + {1'b0, s_v_q};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + random bench for pipe_stage_skid with a FIFO reference model
// and an in-order delivery scoreboard.
module tb_pipe_stage_skid;
  localparam int CW = 11;
  localparam int DW = 48;

  logic          clk = 1'b0;
  logic          rst, in_valid, flush, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          rdy1, v1, nop1;
  logic [CW-1:0] oc1;
  logic [DW-1:0] od1;
  logic [1:0]    occ1;
  logic          rdy0, v0, nop0;
  logic [CW-1:0] oc0;
  logic [DW-1:0] od0;
  logic [1:0]    occ0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .ZERO_DATA_ON_BUBBLE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(v1), .out_ready(out_ready), .out_ctrl(oc1),
    .out_data(od1), .out_nop(nop1), .occupancy(occ1)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .ZERO_DATA_ON_BUBBLE(1'b0)) dut_hold (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(v0), .out_ready(out_ready), .out_ctrl(oc0),
    .out_data(od0), .out_nop(nop0), .occupancy(occ0)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  item_t         mq[$];
  item_t         exq[$];
  logic [DW-1:0] last_d;
  int            tests = 0;
  int            fails = 0;
  int            ndel;
  bit            sb_on;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    int n;
    n = mq.size();
    chk("valid", {63'd0, v1}, {63'd0, n > 0});
    chk("nop", {63'd0, nop1}, {63'd0, n == 0});
    chk("occ", {62'd0, occ1}, 64'(n));
    chk("in_ready", {63'd0, rdy1}, {63'd0, n < 2});
    chk("ctrl", 64'(oc1), n > 0 ? 64'(mq[0].c) : 64'd0);
    chk("data", 64'(od1), n > 0 ? 64'(mq[0].d) : 64'd0);
    chk("h_valid", {63'd0, v0}, {63'd0, n > 0});
    chk("h_ctrl", 64'(oc0), n > 0 ? 64'(mq[0].c) : 64'd0);
    chk("h_data", 64'(od0), n > 0 ? 64'(mq[0].d) : 64'(last_d));
  endtask

  task automatic cyc();
    bit    acc, con;
    item_t it;
    if (sb_on && !rst && !flush && v1 && out_ready) begin
      if (exq.size() == 0) begin
        chk("sb_extra", 64'd1, 64'd0);
      end else begin
        it = exq.pop_front();
        chk("sb_ctrl", 64'(oc1), 64'(it.c));
        chk("sb_data", 64'(od1), 64'(it.d));
        ndel++;
      end
    end
    acc = in_valid && (mq.size() < 2);
    con = (mq.size() > 0) && out_ready;
    if (rst) begin
      mq.delete();
      last_d = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({in_ctrl, in_data});
        if (sb_on) exq.push_back({in_ctrl, in_data});
      end
    end
    if (mq.size() > 0) last_d = mq[0].d;
    @(posedge clk);
    #1;
    chk_state();
  endtask

  initial begin
    int idx, c;
    logic [DW-1:0] cnt;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0; last_d = '0; sb_on = 1'b0; ndel = 0;
    cyc();
    cyc();
    chk("rst_occ", {62'd0, occ1}, 64'd0);
    chk("rst_ready", {63'd0, rdy1}, 64'd1);
    rst = 1'b0;

    // single word, one-cycle latency
    in_valid = 1'b1; in_ctrl = 11'h5A5; in_data = 48'h123456; out_ready = 1'b1;
    cyc();
    chk("t1_valid", {63'd0, v1}, 64'd1);
    chk("t1_ctrl", 64'(oc1), 64'h5A5);
    chk("t1_occ", {62'd0, occ1}, 64'd1);
    in_valid = 1'b0;
    cyc();

    // 10-word stream with a downstream stall
    sb_on = 1'b1; ndel = 0; idx = 1; c = 0;
    while (idx <= 10 && c < 100) begin
      bit pre;
      in_valid = 1'b1;
      in_data = 48'(idx);
      in_ctrl = 11'(idx);
      out_ready = !(c >= 3 && c <= 5);
      pre = mq.size() < 2;
      cyc();
      if (pre) idx++;
      c++;
    end
    chk("stream_timeout", 64'(c < 100), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("stream_cnt", 64'(ndel), 64'd10);
    chk("stream_left", 64'(exq.size()), 64'd0);
    sb_on = 1'b0;

    // fill to FULL then flush with a new input pending
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 11'h0A1; in_data = 48'hAAAA; cyc();
    in_ctrl = 11'h0B2; in_data = 48'hBBBB; cyc();
    chk("full_occ", {62'd0, occ1}, 64'd2);
    flush = 1'b1; in_ctrl = 11'h0C3; in_data = 48'hCCCC;
    cyc();
    chk("fl_valid", {63'd0, v1}, 64'd0);
    chk("fl_ctrl", 64'(oc1), 64'd0);
    chk("fl_data", 64'(od1), 64'd0);
    chk("fl_ready", {63'd0, rdy1}, 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    // bubble while upstream holds junk control
    in_valid = 1'b1; in_ctrl = 11'h011; in_data = 48'hD00D; cyc();
    in_valid = 1'b0; in_ctrl = 11'h7FF; in_data = 48'hBEEF; cyc();
    chk("bub_nop", {63'd0, nop1}, 64'd1);
    chk("bub_ctrl", 64'(oc1), 64'd0);
    chk("bub_hold", 64'(od0), 64'hD00D);

    // reset together with flush at occupancy 2
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 48'h1; in_ctrl = 11'h1; cyc();
    in_data = 48'h2; in_ctrl = 11'h2; cyc();
    chk("pre_rst_occ", {62'd0, occ1}, 64'd2);
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1; in_data = 48'h3;
    cyc();
    chk("rr_occ", {62'd0, occ1}, 64'd0);
    chk("rr_hdata", 64'(od0), 64'd0);
    rst = 1'b0; flush = 1'b0; in_data = 48'h44; in_ctrl = 11'h44;
    cyc();
    chk("post_rst", 64'(od1), 64'h44);
    in_valid = 1'b0;
    cyc();

    // random backpressure, continuous input
    sb_on = 1'b1; ndel = 0; cnt = 48'h100;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bit pre;
      in_data = cnt;
      in_ctrl = 11'($urandom_range(1, 2047));
      out_ready = 1'($urandom_range(0, 1));
      pre = mq.size() < 2;
      cyc();
      if (pre) cnt++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("rnd_left", 64'(exq.size()), 64'd0);
    chk("rnd_cnt", 64'(ndel), 64'(cnt - 48'h100));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
